line_mem_responder: RTL
=======================

# line_mem_responder

Responder end of the cache line-transfer handshake: a parameterized, fixed-latency, line-wide backing memory that services the downstream read/write requests of a cache core. It sits below the last-level cache in the hierarchy and serves as the physical-memory model in cache-hierarchy benches. It latches each request and counts a programmable latency. It then commits or reads one full line and pulses a one-cycle response.

## Interface
- s_offset, 5, byte-offset bits per line; offset bits of the address are ignored.
- s_line, 8*2**s_offset, line width in bits.
- s_depth, 6, line-index bits; the array holds 2**s_depth lines.
- latency, 4, BUSY cycles per request; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  read request, held by the initiator until mem_resp.
- mem_write  in  1  write request, held by the initiator until mem_resp.
- mem_address  in  32  line address; bits [s_offset+s_depth-1:s_offset] select the line.
- mem_wdata  in  s_line  write line.
- mem_rdata  out  s_line  read line; valid in the mem_resp cycle of a read and held until the next read completes.
- mem_resp  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky flag, set on simultaneous read and write.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If mem_read or mem_write is high, capture op, line index and wdata into request registers.
  - Load the counter with latency-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access and go to RESP.
  - A write updates the array line at the captured index with the captured wdata.
  - A read loads mem_rdata from the array line at the captured index.
- RESP:
  - mem_resp=1 for this cycle only; go to IDLE unconditionally.
  - Requests present during RESP are not sampled.
- Inputs are sampled only in IDLE. Changes to address, wdata or op during BUSY or RESP have no effect on the request in flight.
- If read and write are both high in IDLE, the read is served, the write is dropped and proto_err is set. proto_err clears only on rst.
- Address bits above the index alias: lines 0x40 apart (in index) map to the same entry when s_depth=6.
- The counter width is 8 bits and it never wraps. The load value latency-1 is at most 254.

## Timing
- Reset values: state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, counter=0.
- The array contents are not cleared by rst.
- Request first high in IDLE in cycle c gives BUSY in cycles c+1..c+latency, mem_resp=1 in cycle c+latency+1, and IDLE in cycle c+latency+2.
- Throughput: one request per latency+2 cycles.
- An initiator that keeps a request high through the RESP cycle starts a new transaction in the following IDLE cycle. That is the initiator's back-to-back case, and it is served again.
- The array write and the mem_rdata load take effect at the edge that ends the last BUSY cycle. They are visible during RESP.
- A read of a line written by the immediately preceding transaction returns the new data.
- rst asserted during BUSY aborts the transaction: no array write, no mem_resp, and IDLE next cycle.
- rst asserted during RESP: mem_resp is low the next cycle and the completed write remains committed.

## Test plan
- Reset, then hold idle for 10 cycles: mem_resp=0, mem_rdata=0 and proto_err=0 throughout.
- latency=4: write 0xA5…A5 to address 0x0000_0120, then read 0x0000_013F. mem_resp rises exactly 5 cycles after each request is first seen. The read returns 0xA5…A5 because offset bits are ignored.
- Aliasing with s_depth=6: write line X to 0x0000_0000, then write Y to 0x0000_0800. A read of 0x0000_0000 returns Y.
- Mid-flight change: issue a read of 0x40 and switch the address to 0x80 during BUSY. The data returned is line 0x40's.
- Assert rst during the 2nd BUSY cycle of a write to 0x60 containing Z (line previously W). No mem_resp occurs, and a subsequent read of 0x60 returns W.
- Assert read and write together at 0x20: the read data is returned, the line is unchanged, and proto_err=1 persists until rst.

Source files
------------

// File: rtl/line_mem_responder_if.sv
// Cache line-transfer handshake between a cache core (master) and a line memory (slave).
interface line_mem_responder_if #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 8 * 2**s_offset
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [s_line-1:0] mem_wdata;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;
  logic              proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp,
    output proto_err
  );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line-wide backing memory: latches a request, waits `latency` cycles,
// commits or reads one full line and pulses mem_resp for one cycle.
module line_mem_responder #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 8 * 2**s_offset,
  parameter int unsigned s_depth  = 6,
  parameter int unsigned latency  = 4
) (
  input logic                 clk,
  input logic                 rst,
  line_mem_responder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [7:0] count_load = 8'(latency - 1);

  logic [1:0]         state;
  logic [7:0]         count;
  logic               req_write;
  logic [s_depth-1:0] req_index;
  logic [s_line-1:0]  req_wdata;
  logic [s_line-1:0]  rdata;
  logic               proto_err;
  logic               access;

  logic [s_line-1:0]  lines [2**s_depth];

  // Offset bits and bits above the index do not take part in line selection.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_address[31:s_offset+s_depth],
                              bus.mem_address[s_offset-1:0]};

  assign access = (state == BUSY) && (count == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 8'd0;
      req_write <= 1'b0;
      req_index <= '0;
      req_wdata <= '0;
      rdata     <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            // A simultaneous read and write serves the read and drops the write.
            req_write <= bus.mem_write && !bus.mem_read;
            req_index <= bus.mem_address[s_offset +: s_depth];
            req_wdata <= bus.mem_wdata;
            count     <= count_load;
            state     <= BUSY;
            if (bus.mem_read && bus.mem_write) begin
              proto_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (count == 8'd0) begin
            if (!req_write) begin
              rdata <= lines[req_index];
            end
            state <= RESP;
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array contents survive reset; a reset during BUSY suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && access && req_write) begin
      lines[req_index] <= req_wdata;
    end
  end

  assign bus.mem_rdata = rdata;
  assign bus.mem_resp  = (state == RESP);
  assign bus.proto_err = proto_err;

endmodule
